xdma_read_meta_manager: RTL
===========================

Name: xdma_read_meta_manager

Overview:
- Read-side counterpart of the xDMA write meta manager.
- Queues the metadata of issued AXI read requests (DMA ID, beat length) in a small in-order FIFO.
- Counts R-channel handshakes against the head entry and pulses a per-request completion carrying that request's DMA ID.
- Cross-checks beat count against RLAST and flags mismatches. Sits between the xDMA read frontend and the AXI R channel.

Parameters:
IdWidth, 8, width of DMA ID
LenWidth, 16, width of beat-length field (number of R beats per request)
NumOutstanding, 4, metadata FIFO depth (power of two, >=2)
CntWidth, $clog2(NumOutstanding+1), derived; width of outstanding count

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
read_req_valid_i  in  1  new read request metadata valid
read_req_ready_o  out  1  metadata FIFO can accept
read_req_dma_id_i  in  IdWidth  DMA ID of new request
read_req_dma_length_i  in  LenWidth  beats expected for new request
read_happening_i  in  1  AXI R handshake (rvalid & rready) this cycle
read_last_i  in  1  RLAST of the current R beat
read_req_done_o  out  1  head request's final beat handshaked, 1-cycle pulse
done_dma_id_o  out  IdWidth  DMA ID of completing request, valid with read_req_done_o, else 0
cur_dma_id_o  out  IdWidth  DMA ID of head request, 0 when no request outstanding
read_len_error_o  out  1  1-cycle pulse on RLAST mismatch or spurious beat
outstanding_o  out  CntWidth  number of queued requests

Behaviour:
- Reset:
  - FIFO empty, beat counter 0.
  - All outputs 0, except read_req_ready_o = 1.
  - Reset asserted mid-operation discards all queued metadata immediately; no done pulse is emitted.
- Push:
  - Occurs when read_req_valid_i && read_req_ready_o.
  - read_req_ready_o = !full. No combinational path from the pop side; a full FIFO refuses a push even in a cycle where it pops.
  - Pushed entry is visible as head no earlier than the next cycle.
- Head tracking:
  - cur_dma_id_o = head ID when outstanding_o > 0, else 0.
  - Effective length = stored length; a stored length of 0 is treated as 1 beat.
- Beat counting (LenWidth bits, up-counter):
  - Increments on read_happening_i while FIFO non-empty.
  - Final beat: read_happening_i && counter == effective_length-1.
- Completion (combinational, same cycle as final beat):
  - read_req_done_o = 1 and done_dma_id_o = head ID.
  - Head popped and counter cleared to 0 at the next edge.
  - Next request's first beat is counted the following cycle; back-to-back requests need no idle cycle.
- Error (read_len_error_o, same cycle as offending beat):
  - (a) read_last_i = 1 on a non-final beat: counting continues and completion still occurs at the counted final beat.
  - (b) read_last_i = 0 on the final beat: completion still occurs.
  - (c) read_happening_i while FIFO empty: beat ignored, counter unchanged.
- Push and pop in the same cycle: outstanding_o unchanged, entry order preserved.
- outstanding_o is registered and updated at the edge following push/pop.
- Counter never wraps: the final-beat comparison pops before counter exceeds effective_length-1.

Test Plan:
1. Reset, push {id=0x11, len=4}, 4 beats with RLAST on beat 4 -> done pulse with done_dma_id_o=0x11 on beat-4 cycle only; outstanding_o 1 then 0; no error.
2. Push {0x01,len=2} and {0x02,len=3}, 5 contiguous beats, RLAST on beats 2 and 5 -> done on beats 2 (ID 0x01) and 5 (ID 0x02); cur_dma_id_o switches to 0x02 the cycle after beat 2.
3. Push 4 requests with no beats -> read_req_ready_o=0, outstanding_o=4; fifth push held off; one request completes -> ready returns 1 the next cycle.
4. Push {0x33,len=4}, RLAST on beat 2 -> error pulse on beat 2; done still on beat 4; a further case with RLAST missing on beat 4 -> error and done in the same cycle.
5. Beat with FIFO empty -> error pulse, no done, outstanding_o stays 0. Push {0x44,len=0}, one beat -> done with ID 0x44.
6. Reset asserted after 2 of 4 beats with 2 entries queued -> outstanding_o=0, cur_dma_id_o=0, no done. Fresh {0x55,len=1} after reset completes normally.

Source files
------------

// File: rtl/xdma_read_meta_manager.sv
// Read-side metadata tracker for xDMA: queues (DMA ID, beat length) per issued AXI read
// and counts R beats against the head entry to signal per-request completion.
module xdma_read_meta_manager #(
    parameter int unsigned IdWidth        = 8,
    parameter int unsigned LenWidth       = 16,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned CntWidth       = $clog2(NumOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                read_req_valid_i,
    output logic                read_req_ready_o,
    input  logic [IdWidth-1:0]  read_req_dma_id_i,
    input  logic [LenWidth-1:0] read_req_dma_length_i,
    input  logic                read_happening_i,
    input  logic                read_last_i,
    output logic                read_req_done_o,
    output logic [IdWidth-1:0]  done_dma_id_o,
    output logic [IdWidth-1:0]  cur_dma_id_o,
    output logic                read_len_error_o,
    output logic [CntWidth-1:0] outstanding_o
);

    localparam int unsigned PtrWidth = $clog2(NumOutstanding);

    logic [IdWidth-1:0]  id_mem  [NumOutstanding];
    logic [LenWidth-1:0] len_mem [NumOutstanding];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [LenWidth-1:0] beat_cnt_q, beat_cnt_d;

    logic                empty, full, push, pop;
    logic [IdWidth-1:0]  head_id;
    logic [LenWidth-1:0] head_len, last_idx;
    logic                final_beat;

    assign empty = (count_q == '0);
    // Ready depends only on registered occupancy, so a full FIFO refuses a push even when popping.
    assign full  = (count_q == CntWidth'(NumOutstanding));
    assign push  = read_req_valid_i && !full;

    assign head_id  = id_mem[rd_ptr_q];
    assign head_len = len_mem[rd_ptr_q];
    // A stored length of zero is a single-beat request; last beat index is then 0.
    assign last_idx = (head_len == '0) ? '0 : head_len - LenWidth'(1);

    assign final_beat = read_happening_i && !empty && (beat_cnt_q == last_idx);
    assign pop        = final_beat;

    always_comb begin
        read_req_ready_o = !full;
        read_req_done_o  = final_beat;
        done_dma_id_o    = final_beat ? head_id : '0;
        cur_dma_id_o     = empty ? '0 : head_id;
        outstanding_o    = count_q;
        read_len_error_o = read_happening_i && (empty || (read_last_i != final_beat));
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntWidth'(1);
        end

        // Beats arriving with nothing queued are flagged and otherwise ignored.
        if (pop) begin
            beat_cnt_d = '0;
        end else if (read_happening_i && !empty) begin
            beat_cnt_d = beat_cnt_q + LenWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr_q]  <= read_req_dma_id_i;
            len_mem[wr_ptr_q] <= read_req_dma_length_i;
        end
    end

endmodule
